// File: rtl/rv_pkg.sv
// Shared RV32I encodings, FSM state type and exception causes for the
// execute/memory controller and its lane-alignment helper.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] EXC_NONE           = 2'd0;
    localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd1;
    localparam logic [1:0] EXC_STORE_MISALIGN = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL        = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic ls_funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3 inside {F3_LB, F3_LH, F3_LW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data port: byte enables, store replication,
// misalignment detection and load extraction with sign/zero extension.
module lsu_lane_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  i_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  logic [XLEN-1:0]             i_wdata,
    input  logic [XLEN-1:0]             i_rdata,
    output logic [XLEN/8-1:0]           o_be,
    output logic [XLEN-1:0]             o_wdata,
    output logic                        o_misalign,
    output logic [XLEN-1:0]             o_rdata
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0]   w_be_base;
    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_be_base  = '0;
        o_wdata    = '0;
        o_misalign = 1'b0;
        o_rdata    = '0;
        w_sign     = 1'b0;
        w_shifted  = i_rdata >> {i_offset, 3'b000};
        case (i_funct3[1:0])
            SZ_BYTE: begin
                w_be_base    = NB'(1);
                o_wdata      = {NB{i_wdata[7:0]}};
                w_sign       = ~i_funct3[2] & w_shifted[7];
                o_rdata      = {XLEN{w_sign}};
                o_rdata[7:0] = w_shifted[7:0];
            end
            SZ_HALF: begin
                w_be_base     = NB'(3);
                o_wdata       = {(NB/2){i_wdata[15:0]}};
                o_misalign    = i_offset[0];
                w_sign        = ~i_funct3[2] & w_shifted[15];
                o_rdata       = {XLEN{w_sign}};
                o_rdata[15:0] = w_shifted[15:0];
            end
            SZ_WORD: begin
                w_be_base     = NB'(15);
                o_wdata       = {(NB/4){i_wdata[31:0]}};
                o_misalign    = |i_offset[1:0];
                w_sign        = ~i_funct3[2] & w_shifted[31];
                o_rdata       = {XLEN{w_sign}};
                o_rdata[31:0] = w_shifted[31:0];
            end
            default: ;
        endcase
    end

    assign o_be = w_be_base << i_offset;

endmodule

// File: rtl/exec_mem_ctrl.sv
// Multi-cycle execute/memory controller: IDLE -> EXEC -> (MEM) -> WB,
// with a valid/ready data port and registered write-back/redirect outputs.
module exec_mem_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_we,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic              jump_en,
    output logic [XLEN-1:0]   jump_addr,
    output logic              exc,
    output logic [1:0]        exc_cause
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_t          r_state;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1, r_rs2, r_imm, r_pc;

    logic            r_busy, r_done, r_rd_we, r_mem_req, r_mem_we, r_jump_en, r_exc;
    logic [XLEN-1:0] r_rd_wdata, r_mem_addr, r_mem_wdata, r_jump_addr;
    logic [NB-1:0]   r_mem_be;
    logic [1:0]      r_exc_cause;

    logic [XLEN-1:0] w_ea, w_pc_imm, w_link, w_wdata, w_load_data;
    logic [NB-1:0]   w_be;
    logic            w_misalign, w_taken, w_is_store, w_ls_legal, w_br_legal;

    assign w_ea       = r_rs1 + r_imm;
    assign w_pc_imm   = r_pc + r_imm;
    assign w_link     = r_pc + XLEN'(4);
    assign w_is_store = (r_opcode == OPC_STORE);
    assign w_ls_legal = ls_funct3_legal(w_is_store, r_funct3);
    assign w_br_legal = (r_funct3[2:1] != 2'b01);

    always_comb begin
        w_taken = 1'b0;
        case (r_funct3)
            F3_BEQ:  w_taken = (r_rs1 == r_rs2);
            F3_BNE:  w_taken = (r_rs1 != r_rs2);
            F3_BLT:  w_taken = ($signed(r_rs1) <  $signed(r_rs2));
            F3_BGE:  w_taken = ($signed(r_rs1) >= $signed(r_rs2));
            F3_BLTU: w_taken = (r_rs1 <  r_rs2);
            F3_BGEU: w_taken = (r_rs1 >= r_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    lsu_lane_align #(.XLEN(XLEN)) u_lane (
        .i_funct3   (r_funct3),
        .i_offset   (w_ea[OFFW-1:0]),
        .i_wdata    (r_rs2),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign),
        .o_rdata    (w_load_data)
    );

    // NOTE: operand capture registers carry no reset; they are only consumed after a start loads them.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && start) begin
            r_opcode <= opcode;
            r_funct3 <= funct3;
            r_rs1    <= rs1_val;
            r_rs2    <= rs2_val;
            r_imm    <= imm;
            r_pc     <= pc;
        end
    end

    // NOTE: state and outputs update with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_we     <= 1'b0;
            r_rd_wdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_jump_en   <= 1'b0;
            r_jump_addr <= '0;
            r_exc       <= 1'b0;
            r_exc_cause <= EXC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_WB;
                    r_done      <= 1'b1;
                    r_rd_we     <= 1'b0;
                    r_jump_en   <= 1'b0;
                    r_exc       <= 1'b0;
                    r_exc_cause <= EXC_NONE;
                    case (r_opcode)
                        OPC_OP, OPC_OP_IMM: begin
                            r_rd_we    <= 1'b1;
                            r_rd_wdata <= alu_result;
                        end
                        OPC_LUI: begin
                            r_rd_we    <= 1'b1;
                            r_rd_wdata <= r_imm;
                        end
                        OPC_AUIPC: begin
                            r_rd_we    <= 1'b1;
                            r_rd_wdata <= w_pc_imm;
                        end
                        OPC_JAL: begin
                            r_rd_we     <= 1'b1;
                            r_rd_wdata  <= w_link;
                            r_jump_en   <= 1'b1;
                            r_jump_addr <= w_pc_imm;
                        end
                        OPC_JALR: begin
                            r_rd_we     <= 1'b1;
                            r_rd_wdata  <= w_link;
                            r_jump_en   <= 1'b1;
                            r_jump_addr <= {w_ea[XLEN-1:1], 1'b0};
                        end
                        OPC_BRANCH: begin
                            if (w_br_legal) begin
                                r_jump_en   <= w_taken;
                                r_jump_addr <= w_pc_imm;
                            end else begin
                                r_exc       <= 1'b1;
                                r_exc_cause <= EXC_ILLEGAL;
                            end
                        end
                        OPC_LOAD, OPC_STORE: begin
                            if (!w_ls_legal) begin
                                r_exc       <= 1'b1;
                                r_exc_cause <= EXC_ILLEGAL;
                            end else if (ALIGN_CHECK && w_misalign) begin
                                r_exc       <= 1'b1;
                                r_exc_cause <= w_is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                            end else begin
                                // Memory phase: done is deferred until the port handshakes.
                                r_state     <= ST_MEM;
                                r_done      <= 1'b0;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= w_is_store;
                                r_mem_addr  <= {w_ea[XLEN-1:OFFW], {OFFW{1'b0}}};
                                r_mem_be    <= w_be;
                                r_mem_wdata <= w_wdata;
                            end
                        end
                        default: begin
                            r_exc       <= 1'b1;
                            r_exc_cause <= EXC_ILLEGAL;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WB;
                        r_done    <= 1'b1;
                        if (!r_mem_we) begin
                            r_rd_we    <= 1'b1;
                            r_rd_wdata <= w_load_data;
                        end
                    end
                end
                ST_WB: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_rd_we   <= 1'b0;
                    r_jump_en <= 1'b0;
                    r_exc     <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_we     = r_rd_we;
    assign rd_wdata  = r_rd_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign jump_en   = r_jump_en;
    assign jump_addr = r_jump_addr;
    assign exc       = r_exc;
    assign exc_cause = r_exc_cause;

endmodule

// File: tb/tb_exec_mem_ctrl.sv
// Scoreboard bench for exec_mem_ctrl: issue pushes expectations, a done monitor
// and a memory responder/monitor pop and compare them independently.
module tb_exec_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm, pc, alu_result, mem_rdata;
    logic        busy, done, rd_we, mem_req, mem_we, jump_en, exc;
    logic [31:0] rd_wdata, mem_addr, mem_wdata, jump_addr;
    logic [3:0]  mem_be;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    exec_mem_ctrl #(.XLEN(32), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .rd_we(rd_we), .rd_wdata(rd_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .jump_en(jump_en),
        .jump_addr(jump_addr), .exc(exc), .exc_cause(exc_cause)
    );

    localparam logic [6:0] O_OP = 7'b0110011, O_OPI = 7'b0010011, O_LUI = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111, O_JAL = 7'b1101111, O_JALR = 7'b1100111;
    localparam logic [6:0] O_BR = 7'b1100011, O_LD = 7'b0000011, O_ST = 7'b0100011;

    typedef struct {
        string       nm;
        logic        rd_we;
        logic [31:0] rd_wdata;
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        exc;
        logic [1:0]  cause;
        int          lat;
        int          issue_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          wt;
        logic [31:0] rdata;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mem_q[$];
    exp_t  mon_e;
    mexp_t mon_m;
    mexp_t no_m;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    mem_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk_e(input logic we, input logic [31:0] rd, input logic jen,
                                  input logic [31:0] ja, input logic ex, input logic [1:0] cs,
                                  input int lat);
        exp_t e;
        e.nm = ""; e.rd_we = we; e.rd_wdata = rd; e.jump_en = jen; e.jump_addr = ja;
        e.exc = ex; e.cause = cs; e.lat = lat; e.issue_cyc = 0;
        return e;
    endfunction

    function automatic mexp_t mk_m(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                                   input logic we, input int wt, input logic [31:0] rdat);
        mexp_t m;
        m.addr = a; m.be = be; m.wdata = wd; m.we = we; m.wt = wt; m.rdata = rdat;
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Done monitor: every completion pulse must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.nm, ".latency"}, cyc - mon_e.issue_cyc + 1, mon_e.lat);
                check({mon_e.nm, ".rd_we"}, rd_we, mon_e.rd_we);
                check({mon_e.nm, ".jump_en"}, jump_en, mon_e.jump_en);
                check({mon_e.nm, ".exc"}, exc, mon_e.exc);
                check({mon_e.nm, ".exc_cause"}, exc_cause, mon_e.cause);
                if (mon_e.rd_we) check({mon_e.nm, ".rd_wdata"}, rd_wdata, mon_e.rd_wdata);
                if (mon_e.jump_en) check({mon_e.nm, ".jump_addr"}, jump_addr, mon_e.jump_addr);
            end
        end
    end

    // Memory responder: checks the request every cycle it is held, answers after wt waits.
    initial forever begin
        @(negedge clk);
        if (rst || !mem_req) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_q.size() == 0) begin
            check("unexpected_mem_req", mem_req, 0);
            mem_ready = 1'b0;
        end else begin
            mon_m = mem_q[0];
            check("mem.addr", mem_addr, mon_m.addr);
            check("mem.be", mem_be, mon_m.be);
            check("mem.we", mem_we, mon_m.we);
            if (mon_m.we) check("mem.wdata", mem_wdata, mon_m.wdata);
            if (mem_cnt >= mon_m.wt) begin
                mem_ready = 1'b1;
                mem_rdata = mon_m.rdata;
                void'(mem_q.pop_front());
                mem_cnt = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                mem_cnt++;
            end
        end
    end

    task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic [31:0] alu, input bit want_done,
                         input exp_t e, input bit has_m, input mexp_t m);
        int n;
        n = 0;
        @(negedge clk);
        opcode = op; funct3 = f3; rs1_val = a; rs2_val = b; imm = im; pc = p;
        alu_result = alu; start = 1'b1;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({nm, ".accept_timeout"}, busy, 0);
        e.nm = nm;
        e.issue_cyc = cyc;
        if (want_done) exp_q.push_back(e);
        if (has_m) mem_q.push_back(m);
        @(negedge clk);
        start = 1'b0;
        opcode = 7'($urandom); funct3 = 3'($urandom);
        rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; pc = $urandom;
    endtask

    initial begin
        int n;
        no_m = mk_m(0, 0, 0, 0, 0, 0);
        rst = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; rs1_val = '0; rs2_val = '0;
        imm = '0; pc = '0; alu_result = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.rd_we", rd_we, 0);
        check("reset.mem_req", mem_req, 0);
        check("reset.jump_en", jump_en, 0);
        check("reset.exc", exc, 0);
        check("reset.exc_cause", exc_cause, 0);
        check("reset.mem_be", mem_be, 0);
        check("reset.rd_wdata", rd_wdata, 0);
        rst = 1'b0;

        issue("lw_aligned", O_LD, 3'b010, 32'h100, 0, 32'h4, 0, 0, 1,
              mk_e(1, 32'hDEADBEEF, 0, 0, 0, 0, 6), 1, mk_m(32'h104, 4'hF, 0, 0, 2, 32'hDEADBEEF));
        issue("lb_103", O_LD, 3'b000, 32'h100, 0, 32'h3, 0, 0, 1,
              mk_e(1, 32'hFFFFFF80, 0, 0, 0, 0, 4), 1, mk_m(32'h100, 4'h8, 0, 0, 0, 32'h80123456));
        issue("lbu_103", O_LD, 3'b100, 32'h100, 0, 32'h3, 0, 0, 1,
              mk_e(1, 32'h00000080, 0, 0, 0, 0, 7), 1, mk_m(32'h100, 4'h8, 0, 0, 3, 32'h80123456));
        issue("lh_102", O_LD, 3'b001, 32'h100, 0, 32'h2, 0, 0, 1,
              mk_e(1, 32'hFFFF8001, 0, 0, 0, 0, 4), 1, mk_m(32'h100, 4'hC, 0, 0, 0, 32'h80017FFF));
        issue("lhu_102", O_LD, 3'b101, 32'h100, 0, 32'h2, 0, 0, 1,
              mk_e(1, 32'h00008001, 0, 0, 0, 0, 4), 1, mk_m(32'h100, 4'hC, 0, 0, 0, 32'h80017FFF));
        issue("lh_100", O_LD, 3'b001, 32'hF0, 0, 32'h10, 0, 0, 1,
              mk_e(1, 32'h00007FFF, 0, 0, 0, 0, 4), 1, mk_m(32'h100, 4'h3, 0, 0, 0, 32'h80017FFF));
        issue("sh_202", O_ST, 3'b001, 32'h200, 32'h1234ABCD, 32'h2, 0, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 5), 1, mk_m(32'h200, 4'hC, 32'hABCDABCD, 1, 1, 0));
        issue("sb_301", O_ST, 3'b000, 32'h300, 32'h000055AB, 32'h1, 0, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 4), 1, mk_m(32'h300, 4'h2, 32'hABABABAB, 1, 0, 0));
        issue("sw_408", O_ST, 3'b010, 32'h400, 32'hCAFEF00D, 32'h8, 0, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 4), 1, mk_m(32'h408, 4'hF, 32'hCAFEF00D, 1, 0, 0));
        issue("blt_taken", O_BR, 3'b100, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h40, 0, 1,
              mk_e(0, 0, 1, 32'h38, 0, 0, 3), 0, no_m);
        issue("bltu_not", O_BR, 3'b110, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h40, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 3), 0, no_m);
        issue("beq_taken", O_BR, 3'b000, 32'h5, 32'h5, 32'h10, 32'h200, 0, 1,
              mk_e(0, 0, 1, 32'h210, 0, 0, 3), 0, no_m);
        issue("bne_not", O_BR, 3'b001, 32'h5, 32'h5, 32'h10, 32'h200, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 3), 0, no_m);
        issue("bge_taken", O_BR, 3'b101, 32'h1, 32'hFFFFFFFF, 32'h20, 32'h300, 0, 1,
              mk_e(0, 0, 1, 32'h320, 0, 0, 3), 0, no_m);
        issue("bgeu_not", O_BR, 3'b111, 32'h1, 32'hFFFFFFFF, 32'h20, 32'h300, 0, 1,
              mk_e(0, 0, 0, 0, 0, 0, 3), 0, no_m);
        issue("br_f3_010", O_BR, 3'b010, 32'h1, 32'h1, 32'h20, 32'h300, 0, 1,
              mk_e(0, 0, 0, 0, 1, 3, 3), 0, no_m);
        issue("jalr", O_JALR, 3'b000, 32'h1001, 0, 32'h2, 32'h80, 0, 1,
              mk_e(1, 32'h84, 1, 32'h1002, 0, 0, 3), 0, no_m);
        issue("jal", O_JAL, 3'b000, 0, 0, 32'h20, 32'h100, 0, 1,
              mk_e(1, 32'h104, 1, 32'h120, 0, 0, 3), 0, no_m);
        issue("lui", O_LUI, 3'b000, 32'h77, 0, 32'h12345000, 32'h500, 0, 1,
              mk_e(1, 32'h12345000, 0, 0, 0, 0, 3), 0, no_m);
        issue("auipc", O_AUIPC, 3'b000, 0, 0, 32'h2000, 32'h1000, 0, 1,
              mk_e(1, 32'h3000, 0, 0, 0, 0, 3), 0, no_m);
        issue("op_add", O_OP, 3'b000, 32'h11, 32'h22, 0, 0, 32'h5555AAAA, 1,
              mk_e(1, 32'h5555AAAA, 0, 0, 0, 0, 3), 0, no_m);
        issue("op_imm", O_OPI, 3'b000, 32'h40, 0, 32'h2, 0, 32'h00000042, 1,
              mk_e(1, 32'h00000042, 0, 0, 0, 0, 3), 0, no_m);
        issue("lw_misalign", O_LD, 3'b010, 32'h100, 0, 32'h2, 0, 0, 1,
              mk_e(0, 0, 0, 0, 1, 1, 3), 0, no_m);
        issue("lh_misalign", O_LD, 3'b001, 32'h100, 0, 32'h1, 0, 0, 1,
              mk_e(0, 0, 0, 0, 1, 1, 3), 0, no_m);
        issue("sw_misalign", O_ST, 3'b010, 32'h200, 32'h1, 32'h1, 0, 0, 1,
              mk_e(0, 0, 0, 0, 1, 2, 3), 0, no_m);
        issue("opcode_7f", 7'h7F, 3'b000, 0, 0, 0, 0, 0, 1,
              mk_e(0, 0, 0, 0, 1, 3, 3), 0, no_m);

        // Reset while a load is stalled in MEM: request must drop and nothing may complete.
        issue("rst_in_mem", O_LD, 3'b010, 32'h500, 0, 0, 0, 0, 0,
              mk_e(0, 0, 0, 0, 0, 0, 0), 1, mk_m(32'h500, 4'hF, 0, 0, 50, 0));
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_mem.req_seen", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_mem.mem_req", mem_req, 0);
        check("rst_in_mem.busy", busy, 0);
        check("rst_in_mem.done", done, 0);
        rst = 1'b0;
        if (mem_q.size() > 0) void'(mem_q.pop_front());
        repeat (4) @(negedge clk);
        check("rst_in_mem.idle_after", busy, 0);

        issue("lw_after_rst", O_LD, 3'b010, 32'h600, 0, 32'hC, 0, 0, 1,
              mk_e(1, 32'h0BADF00D, 0, 0, 0, 0, 4), 1, mk_m(32'h60C, 4'hF, 0, 0, 0, 32'h0BADF00D));

        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain.exp_q", exp_q.size(), 0);
        check("drain.mem_q", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
